// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the memory-access stage.
// The master modport is the pipeline side; the slave modport is mem_stage itself.
interface mem_stage_if;
   logic        memRead_EX_MEM;
   logic        memWrite_EX_MEM;
   logic        memToReg_EX_MEM;
   logic        regWrite_EX_MEM;
   logic [4:0]  destReg_EX_MEM;
   logic [31:0] memData_EX_MEM;
   logic [31:0] aluOut_EX_MEM;
   logic        stall;
   logic        regWrite_MEM_WB;
   logic        memToReg_MEM_WB;
   logic [4:0]  destReg_MEM_WB;
   logic [31:0] readData_MEM_WB;
   logic [31:0] aluOut_MEM_WB;
   logic        misaligned;

   modport master (
      output memRead_EX_MEM, memWrite_EX_MEM, memToReg_EX_MEM, regWrite_EX_MEM,
             destReg_EX_MEM, memData_EX_MEM, aluOut_EX_MEM,
      input  stall, regWrite_MEM_WB, memToReg_MEM_WB, destReg_MEM_WB,
             readData_MEM_WB, aluOut_MEM_WB, misaligned
   );

   modport slave (
      input  memRead_EX_MEM, memWrite_EX_MEM, memToReg_EX_MEM, regWrite_EX_MEM,
             destReg_EX_MEM, memData_EX_MEM, aluOut_EX_MEM,
      output stall, regWrite_MEM_WB, memToReg_MEM_WB, destReg_MEM_WB,
             readData_MEM_WB, aluOut_MEM_WB, misaligned
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word-addressed data memory with a fixed multi-cycle
// latency, stalling the upstream pipeline until each aligned access completes.
module mem_stage #(
   parameter int MEM_LATENCY = 2,
   parameter int DEPTH_LOG2  = 8
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);

   typedef enum logic {IDLE, BUSY} stateType;

   stateType               state;
   logic [3:0]             cnt;
   logic [31:0]            mem [2**DEPTH_LOG2];
   logic                   req;
   logic                   aligned;
   logic                   complete;
   logic [DEPTH_LOG2-1:0]  idx;

   assign req      = bus.memRead_EX_MEM | bus.memWrite_EX_MEM;
   assign aligned  = (bus.aluOut_EX_MEM[1:0] == 2'b00);
   assign idx      = bus.aluOut_EX_MEM[DEPTH_LOG2+1:2];
   assign complete = (state == BUSY) && (cnt == 4'd0);

   // Stall covers the request cycle plus all but the last busy cycle.
   assign bus.stall = !reset &&
                      (((state == IDLE) && req && aligned) ||
                       ((state == BUSY) && (cnt != 4'd0)));

   // Memory has no reset; a pending store is dropped if reset lands on its edge.
   always_ff @(posedge clk) begin
      if (!reset && complete && bus.memWrite_EX_MEM)
         mem[idx] <= bus.memData_EX_MEM;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         cnt                 <= 4'd0;
         bus.regWrite_MEM_WB <= 1'b0;
         bus.memToReg_MEM_WB <= 1'b0;
         bus.destReg_MEM_WB  <= 5'd0;
         bus.readData_MEM_WB <= 32'd0;
         bus.aluOut_MEM_WB   <= 32'd0;
         bus.misaligned      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req && aligned) begin
                  state               <= BUSY;
                  cnt                 <= 4'(MEM_LATENCY - 1);
                  bus.regWrite_MEM_WB <= 1'b0;
                  bus.memToReg_MEM_WB <= 1'b0;
                  bus.misaligned      <= 1'b0;
               end else begin
                  // Non-memory and misaligned instructions both retire with zero read data.
                  bus.regWrite_MEM_WB <= bus.regWrite_EX_MEM && !req;
                  bus.memToReg_MEM_WB <= bus.memToReg_EX_MEM;
                  bus.destReg_MEM_WB  <= bus.destReg_EX_MEM;
                  bus.aluOut_MEM_WB   <= bus.aluOut_EX_MEM;
                  bus.readData_MEM_WB <= 32'd0;
                  bus.misaligned      <= req;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt                 <= cnt - 4'd1;
                  bus.regWrite_MEM_WB <= 1'b0;
                  bus.memToReg_MEM_WB <= 1'b0;
                  bus.misaligned      <= 1'b0;
               end else begin
                  state               <= IDLE;
                  bus.regWrite_MEM_WB <= bus.regWrite_EX_MEM;
                  bus.memToReg_MEM_WB <= bus.memToReg_EX_MEM;
                  bus.destReg_MEM_WB  <= bus.destReg_EX_MEM;
                  bus.aluOut_MEM_WB   <= bus.aluOut_EX_MEM;
                  bus.misaligned      <= 1'b0;
                  if (!bus.memWrite_EX_MEM)
                     bus.readData_MEM_WB <= mem[idx];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at latency 2 and one at latency 1
// to cover the single-stall case and address aliasing.
module tb_mem_stage;

   logic clk;
   logic reset;
   int   testCount;
   int   failCount;

   mem_stage_if busA ();
   mem_stage_if busB ();

   mem_stage #(.MEM_LATENCY(2), .DEPTH_LOG2(8)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   mem_stage #(.MEM_LATENCY(1), .DEPTH_LOG2(8)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input bit selB, input bit rd, input bit wr, input bit m2r,
                                input bit rw, input logic [4:0] dest,
                                input logic [31:0] data, input logic [31:0] alu);
      if (selB) begin
         busB.memRead_EX_MEM  = rd;
         busB.memWrite_EX_MEM = wr;
         busB.memToReg_EX_MEM = m2r;
         busB.regWrite_EX_MEM = rw;
         busB.destReg_EX_MEM  = dest;
         busB.memData_EX_MEM  = data;
         busB.aluOut_EX_MEM   = alu;
      end else begin
         busA.memRead_EX_MEM  = rd;
         busA.memWrite_EX_MEM = wr;
         busA.memToReg_EX_MEM = m2r;
         busA.regWrite_EX_MEM = rw;
         busA.destReg_EX_MEM  = dest;
         busA.memData_EX_MEM  = data;
         busA.aluOut_EX_MEM   = alu;
      end
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      reset = 1'b1;
      applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      applyStimulus(1'b1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

      tick();
      tick();
      checkOutput("rstRegWrite", busA.regWrite_MEM_WB, 32'd0);
      checkOutput("rstMemToReg", busA.memToReg_MEM_WB, 32'd0);
      checkOutput("rstDestReg",  busA.destReg_MEM_WB, 32'd0);
      checkOutput("rstReadData", busA.readData_MEM_WB, 32'd0);
      checkOutput("rstAluOut",   busA.aluOut_MEM_WB, 32'd0);
      checkOutput("rstMisalign", busA.misaligned, 32'd0);
      checkOutput("rstStall",    busA.stall, 32'd0);
      reset = 1'b0;

      // ALU pass-through
      applyStimulus(1'b0, 0, 0, 0, 1, 5'd5, 32'd0, 32'h0000_1234);
      checkOutput("aluStall", busA.stall, 32'd0);
      tick();
      checkOutput("aluRegWrite", busA.regWrite_MEM_WB, 32'd1);
      checkOutput("aluDestReg",  busA.destReg_MEM_WB, 32'd5);
      checkOutput("aluAluOut",   busA.aluOut_MEM_WB, 32'h0000_1234);
      checkOutput("aluReadData", busA.readData_MEM_WB, 32'd0);
      checkOutput("aluStallAfter", busA.stall, 32'd0);

      // Store 0xDEADBEEF to 0x10
      applyStimulus(1'b0, 0, 1, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0010);
      checkOutput("stStall1", busA.stall, 32'd1);
      tick();
      checkOutput("stStall2", busA.stall, 32'd1);
      checkOutput("stRegWrite1", busA.regWrite_MEM_WB, 32'd0);
      tick();
      checkOutput("stStallDone", busA.stall, 32'd0);
      checkOutput("stRegWrite2", busA.regWrite_MEM_WB, 32'd0);
      tick();
      checkOutput("stRegWrite3", busA.regWrite_MEM_WB, 32'd0);

      // Back-to-back load from 0x10
      applyStimulus(1'b0, 1, 0, 1, 1, 5'd8, 32'd0, 32'h0000_0010);
      checkOutput("ldStall1", busA.stall, 32'd1);
      tick();
      checkOutput("ldStall2", busA.stall, 32'd1);
      checkOutput("ldBubble", busA.regWrite_MEM_WB, 32'd0);
      tick();
      checkOutput("ldStallDone", busA.stall, 32'd0);
      tick();
      checkOutput("ldReadData", busA.readData_MEM_WB, 32'hDEAD_BEEF);
      checkOutput("ldDestReg",  busA.destReg_MEM_WB, 32'd8);
      checkOutput("ldRegWrite", busA.regWrite_MEM_WB, 32'd1);
      checkOutput("ldMemToReg", busA.memToReg_MEM_WB, 32'd1);

      // Misaligned load at 0x12
      applyStimulus(1'b0, 1, 0, 1, 1, 5'd9, 32'd0, 32'h0000_0012);
      checkOutput("misStall", busA.stall, 32'd0);
      tick();
      checkOutput("misFlag",     busA.misaligned, 32'd1);
      checkOutput("misRegWrite", busA.regWrite_MEM_WB, 32'd0);
      checkOutput("misReadData", busA.readData_MEM_WB, 32'd0);
      checkOutput("misDestReg",  busA.destReg_MEM_WB, 32'd9);
      checkOutput("misAluOut",   busA.aluOut_MEM_WB, 32'h0000_0012);
      applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      tick();
      checkOutput("misPulseEnd", busA.misaligned, 32'd0);

      // Preload mem[8] = 0x11111111 via address 0x20
      applyStimulus(1'b0, 0, 1, 0, 0, 5'd0, 32'h1111_1111, 32'h0000_0020);
      tick();
      tick();
      tick();

      // Store 0x55 to 0x20, killed by reset in the second stall cycle
      applyStimulus(1'b0, 0, 1, 0, 0, 5'd0, 32'h0000_0055, 32'h0000_0020);
      checkOutput("rmStall1", busA.stall, 32'd1);
      tick();
      reset = 1'b1;
      #1;
      checkOutput("rmStallReset", busA.stall, 32'd0);
      tick();
      reset = 1'b0;
      checkOutput("rmRegWrite", busA.regWrite_MEM_WB, 32'd0);
      applyStimulus(1'b0, 1, 0, 1, 1, 5'd10, 32'd0, 32'h0000_0020);
      checkOutput("rmLdStall", busA.stall, 32'd1);
      tick();
      tick();
      tick();
      checkOutput("rmReadData", busA.readData_MEM_WB, 32'h1111_1111);
      checkOutput("rmDestReg",  busA.destReg_MEM_WB, 32'd10);
      applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

      // Latency 1: store 0xCAFE to 0x400, load 0x000 aliases to the same word
      applyStimulus(1'b1, 0, 1, 0, 0, 5'd0, 32'h0000_CAFE, 32'h0000_0400);
      checkOutput("l1StStall", busB.stall, 32'd1);
      tick();
      checkOutput("l1StStallDone", busB.stall, 32'd0);
      tick();
      applyStimulus(1'b1, 1, 0, 1, 1, 5'd3, 32'd0, 32'h0000_0000);
      checkOutput("l1LdStall", busB.stall, 32'd1);
      tick();
      checkOutput("l1LdStallDone", busB.stall, 32'd0);
      checkOutput("l1LdBubble", busB.regWrite_MEM_WB, 32'd0);
      tick();
      checkOutput("l1ReadData", busB.readData_MEM_WB, 32'h0000_CAFE);
      checkOutput("l1RegWrite", busB.regWrite_MEM_WB, 32'd1);
      checkOutput("l1DestReg",  busB.destReg_MEM_WB, 32'd3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
